// File: rtl/mod_addsub_ctrl.sv
// mod_addsub_ctrl: sequences one or two shared-adder operations to produce (x +/- y) mod M
module mod_addsub_ctrl #(
  parameter int N       = 1027,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [N-1:0] in_x,
  input  logic [N-1:0] in_y,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         error,
  output logic         add_start,
  output logic         add_subtract,
  output logic [N-1:0] add_in_a,
  output logic [N-1:0] add_in_b,
  input  logic [N:0]   add_result,
  input  logic         add_done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, OP1, W1, OP2, W2, FIN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   m_q, m_d, t_q, t_d, result_q, result_d, a_q, a_d, b_q, b_d;
  logic           sub_q, sub_d, done_q, done_d, busy_q, busy_d, error_q, error_d;
  logic           as_q, as_d, asub_q, asub_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           accept, timeout;

  // x and y live only in the adder operand registers; they are loaded on accept
  assign accept  = state_q == IDLE && start && !busy_q;
  assign timeout = (state_q == W1 || state_q == W2) && !add_done && cnt_q == CW'(TIMEOUT - 1);

  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;

  // next-state logic: a subtract without borrow skips the correction step
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? OP1 : IDLE;
      OP1:     state_d = W1;
      W1:      state_d = add_done ? ((sub_q && !add_result[N]) ? FIN : OP2) : (timeout ? IDLE : W1);
      OP2:     state_d = W2;
      W2:      state_d = add_done ? FIN : (timeout ? IDLE : W2);
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values of the registered outputs and datapath
  always_comb begin
    m_d      = m_q;
    sub_d    = sub_q;
    t_d      = t_q;
    result_d = result_q;
    error_d  = error_q;
    a_d      = a_q;
    b_d      = b_q;
    asub_d   = asub_q;
    done_d   = 1'b0;
    if (accept) begin
      m_d     = in_m;
      sub_d   = subtract;
      error_d = 1'b0;
      a_d     = in_x;
      b_d     = in_y;
      asub_d  = subtract;
    end
    if (state_q == W1 && add_done) begin
      t_d    = add_result[N-1:0];
      a_d    = add_result[N-1:0];
      b_d    = m_q;
      asub_d = !sub_q;
    end
    if (state_q == W2 && add_done)
      t_d = (!sub_q && add_result[N]) ? t_q : add_result[N-1:0];
    if (timeout) begin
      done_d   = 1'b1;
      error_d  = 1'b1;
      result_d = '0;
    end
    if (state_q == FIN) begin
      done_d   = 1'b1;
      result_d = t_q;
    end
    as_d   = state_d == OP1 || state_d == OP2;
    busy_d = state_d != IDLE || done_d;
    cnt_d  = as_d ? '0 : (state_q inside {OP1, W1, OP2, W2}) ? cnt_q + 1'b1 : cnt_q;
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      m_q      <= '0;
      sub_q    <= 1'b0;
      t_q      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      asub_q   <= 1'b0;
      done_q   <= 1'b0;
      as_q     <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      m_q      <= m_d;
      sub_q    <= sub_d;
      t_q      <= t_d;
      result_q <= result_d;
      error_q  <= error_d;
      a_q      <= a_d;
      b_q      <= b_d;
      asub_q   <= asub_d;
      done_q   <= done_d;
      as_q     <= as_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end

  assign result       = result_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign error        = error_q;
  assign add_start    = as_q;
  assign add_subtract = asub_q;
  assign add_in_a     = a_q;
  assign add_in_b     = b_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// tb_mod_addsub_ctrl: directed scoreboard bench with a behavioural multi-cycle adder
module tb_mod_addsub_ctrl;
  localparam int N  = 1027;
  localparam int TO = 64;
  typedef logic [N:0]   w_t;
  typedef logic [N-1:0] op_t;

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, subtract = 1'b0;
  op_t  in_x = '0, in_y = '0, in_m = '0;
  op_t  result, add_in_a, add_in_b;
  logic done, busy, error, add_start, add_subtract;
  w_t   add_result = '0;
  logic add_done = 1'b0;

  mod_addsub_ctrl #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
    .in_x(in_x), .in_y(in_y), .in_m(in_m), .result(result), .done(done),
    .busy(busy), .error(error), .add_start(add_start), .add_subtract(add_subtract),
    .add_in_a(add_in_a), .add_in_b(add_in_b), .add_result(add_result), .add_done(add_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_t  res;
    logic err;
    int   starts;
    int   lat;
    logic op2_sub;
    op_t  op2_b;
    int   t0;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_cmp = 0, n_fail = 0, cyc = 0, lat_cfg = 3, mcnt = 0, nstart = 0;
  logic hold = 1'b0, inj = 1'b0, prev_as = 1'b0, prev_done = 1'b0, last_sub = 1'b0, cap_s = 1'b0;
  op_t  last_b = '0, cap_a = '0, cap_b = '0, mx;

  task automatic chk(input string name, input w_t act, input w_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // adder model: add_done lat_cfg cycles after add_start, bit N is carry/borrow
  always @(negedge clk) begin
    add_done = inj;
    if (!resetn) mcnt = 0;
    else if (add_start && !hold) begin
      cap_a = add_in_a;
      cap_b = add_in_b;
      cap_s = add_subtract;
      mcnt  = lat_cfg;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        chk("opnd_a_stable", w_t'(add_in_a), w_t'(cap_a));
        chk("opnd_b_stable", w_t'(add_in_b), w_t'(cap_b));
        chk("opnd_mode_stable", w_t'(add_subtract), w_t'(cap_s));
        add_result = cap_s ? {1'b0, cap_a} - {1'b0, cap_b} : {1'b0, cap_a} + {1'b0, cap_b};
        add_done   = 1'b1;
      end
    end
  end

  // monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (!resetn) begin
      nstart    = 0;
      prev_as   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (add_start) begin
        chk("add_start_single", w_t'(prev_as), w_t'(0));
        nstart++;
        last_sub = add_subtract;
        last_b   = add_in_b;
      end
      if (done) begin
        chk("done_single", w_t'(prev_done), w_t'(0));
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_done: got done with result %h, want no done", result[127:0]);
        end else begin
          me = sb.pop_front();
          chk("result", w_t'(result), w_t'(me.res));
          chk("error", w_t'(error), w_t'(me.err));
          chk("add_start_count", w_t'(nstart), w_t'(me.starts));
          chk("latency", w_t'(cyc - me.t0), w_t'(me.lat));
          if (me.starts == 2) begin
            chk("op2_mode", w_t'(last_sub), w_t'(me.op2_sub));
            chk("op2_b", w_t'(last_b), w_t'(me.op2_b));
          end
        end
        nstart = 0;
      end
      prev_as   = add_start;
      prev_done = done;
    end
  end

  task automatic issue(input op_t x, input op_t y, input op_t m, input logic s, input op_t r,
                       input logic err, input int ns, input int lat, input logic o2s, input op_t o2b);
    exp_t e;
    @(negedge clk);
    e.res = r; e.err = err; e.starts = ns; e.lat = lat; e.op2_sub = o2s; e.op2_b = o2b; e.t0 = cyc;
    sb.push_back(e);
    start = 1'b1; subtract = s; in_x = x; in_y = y; in_m = m;
    @(negedge clk);
    start = 1'b0; subtract = ~s; in_x = ~x; in_y = ~y; in_m = ~m;
    chk("busy_after_start", w_t'(busy), w_t'(1));
  endtask

  task automatic wait_done(input logic poke);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done in 300 cycles, want done");
    end else if (poke) begin
      start = 1'b1; subtract = 1'b0; in_x = op_t'(1); in_y = op_t'(1); in_m = op_t'(13);
      @(negedge clk);
      start = 1'b0;
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, want finish");
    $fatal(1);
  end

  initial begin
    mx = {1'b0, {(N-1){1'b1}}};
    repeat (2) @(negedge clk);
    chk("rst_ctrl", w_t'({done, busy, error, add_start, add_subtract}), w_t'(0));
    chk("rst_result", w_t'(result), w_t'(0));
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    // add no wrap, add with wrap, sub no wrap, sub with wrap (adder latency 3)
    issue(op_t'(5), op_t'(6), op_t'(13), 1'b0, op_t'(11), 1'b0, 2, 10, 1'b1, op_t'(13)); wait_done(1'b1);
    issue(op_t'(9), op_t'(7), op_t'(13), 1'b0, op_t'(3), 1'b0, 2, 10, 1'b1, op_t'(13)); wait_done(1'b0);
    issue(op_t'(9), op_t'(4), op_t'(13), 1'b1, op_t'(5), 1'b0, 1, 6, 1'b0, op_t'(0)); wait_done(1'b1);
    issue(op_t'(4), op_t'(9), op_t'(13), 1'b1, op_t'(8), 1'b0, 2, 10, 1'b0, op_t'(13)); wait_done(1'b0);
    // width extremes
    issue(mx - 1, mx - 1, mx, 1'b0, mx - 2, 1'b0, 2, 10, 1'b1, mx); wait_done(1'b0);
    issue(op_t'(0), mx - 1, mx, 1'b1, op_t'(1), 1'b0, 2, 10, 1'b0, mx); wait_done(1'b0);
    // slower adder
    lat_cfg = 5;
    issue(op_t'(9), op_t'(7), op_t'(13), 1'b0, op_t'(3), 1'b0, 2, 14, 1'b1, op_t'(13)); wait_done(1'b0);
    issue(op_t'(9), op_t'(4), op_t'(13), 1'b1, op_t'(5), 1'b0, 1, 8, 1'b0, op_t'(0)); wait_done(1'b0);
    lat_cfg = 3;
    // start while busy is ignored
    issue(op_t'(5), op_t'(6), op_t'(13), 1'b0, op_t'(11), 1'b0, 2, 10, 1'b1, op_t'(13));
    repeat (3) @(negedge clk);
    start = 1'b1; subtract = 1'b1; in_x = op_t'(1); in_y = op_t'(2); in_m = op_t'(13);
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0);
    // watchdog: adder never answers, then a late add_done is ignored
    hold = 1'b1;
    issue(op_t'(5), op_t'(6), op_t'(13), 1'b0, op_t'(0), 1'b1, 1, TO + 1, 1'b0, op_t'(0)); wait_done(1'b0);
    hold = 1'b0;
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    repeat (10) @(negedge clk);
    chk("error_sticky", w_t'(error), w_t'(1));
    // error clears on the next accepted start
    issue(op_t'(9), op_t'(4), op_t'(13), 1'b1, op_t'(5), 1'b0, 1, 6, 1'b0, op_t'(0)); wait_done(1'b0);
    // reset during W1 abandons the operation
    @(negedge clk);
    start = 1'b1; subtract = 1'b0; in_x = op_t'(5); in_y = op_t'(6); in_m = op_t'(13);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_ctrl", w_t'({done, busy, error, add_start, add_subtract}), w_t'(0));
    chk("midrst_result", w_t'(result), w_t'(0));
    chk("midrst_a", w_t'(add_in_a), w_t'(0));
    chk("midrst_b", w_t'(add_in_b), w_t'(0));
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    issue(op_t'(4), op_t'(9), op_t'(13), 1'b1, op_t'(8), 1'b0, 2, 10, 1'b0, op_t'(13)); wait_done(1'b0);
    chk("scoreboard_drained", w_t'(sb.size()), w_t'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mod_addsub_ctrl.md
Name: mod_addsub_ctrl

Overview:
Sequencer that computes modular addition and subtraction, (x + y) mod M or (x − y) mod M, on 1027-bit operands. It does this by issuing one or two operations to the shared multi-cycle 1027-bit adder/subtractor (mpadder) and selecting the final result from the sign of the intermediate value. It sits between the exponentiation/Montgomery control logic and the adder, and owns the adder's start, subtract and operand inputs. A watchdog flags an adder that never completes.

Parameters:
N, 1027, operand width; the adder interface is N+1 bits on the result.
TIMEOUT, 64, maximum cycles to wait for add_done after each add_start before aborting.

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
start  in  1  single-cycle request pulse; accepted only when busy=0.
subtract  in  1  0 = modular add, 1 = modular subtract; sampled with start.
in_x  in  N  operand x; requires x < M.
in_y  in  N  operand y; requires y < M.
in_m  in  N  modulus M; requires 0 < M < 2^(N−1).
result  out  N  (x ± y) mod M; valid from the done pulse until the next accepted start.
done  out  1  single-cycle completion pulse.
busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
error  out  1  sticky watchdog flag; cleared on an accepted start.
add_start  out  1  single-cycle start pulse to the adder.
add_subtract  out  1  adder mode for the current operation.
add_in_a  out  N  adder operand a.
add_in_b  out  N  adder operand b.
add_result  in  N+1  adder result. In subtract mode, bit N = 1 means a − b < 0.
add_done  in  1  adder completion pulse.

Behaviour:
- Reset (async, resetn=0): FSM returns to IDLE. result, done, busy, error, add_start, add_subtract, add_in_a, add_in_b all go to 0. The watchdog counter clears. Reset mid-operation abandons the operation with no done pulse.
- On an accepted start: x, y, M and subtract are latched into internal registers. Input changes after that cycle have no effect.
- FSM states:
  - IDLE: wait for start, then go to OP1.
  - OP1: drive adder operands; pulse add_start for 1 cycle; go to W1.
  - W1: wait for add_done; latch add_result as T.
  - OP2: drive adder operands; pulse add_start for 1 cycle; go to W2.
  - W2: wait for add_done; latch add_result as U.
  - FIN: drive result, pulse done; go to IDLE.
- OP1: add → a=x, b=y, add_subtract=0; sub → a=x, b=y, add_subtract=1.
- After W1:
  - add → T = x + y (< 2^N); go to OP2 with a=T[N−1:0], b=M, add_subtract=1.
  - sub, T[N]=0 → result = T[N−1:0]; go to FIN with no second adder op.
  - sub, T[N]=1 → go to OP2 with a=T[N−1:0], b=M, add_subtract=0.
- After W2:
  - add → result = U[N]=1 ? T[N−1:0] : U[N−1:0].
  - sub → result = U[N−1:0], the low N bits, which discards the wraparound.
- Operand/mode stability: add_in_a, add_in_b and add_subtract are registered. They are valid in the add_start cycle and held constant until add_done is seen.
- Latency from start to done:
  - add: 2 adder latencies + 4 cycles.
  - sub with no wrap: 1 adder latency + 3 cycles.
  - sub with wrap: same as add.
- start while busy=1 is ignored: no latch, no effect on the operation in flight.
- start in the same cycle as done (FIN) is ignored. A new start is accepted from the next cycle.
- add_done in IDLE, OP1 or OP2, or a second add_done within one wait, is ignored.
- Watchdog:
  - The counter clears on each add_start and increments every cycle in W1/W2.
  - If it reaches TIMEOUT without add_done: set error=1, pulse done with result=0, return to IDLE.
  - A late add_done after the abort is ignored.
- done and add_start are never asserted for more than 1 consecutive cycle.

Test Plan:
- Add no wrap: M=13, x=5, y=6, subtract=0 → exactly two add_start pulses (second with add_subtract=1, b=13); result=11; done pulse; error=0.
- Add with wrap: M=13, x=9, y=7 → T=16, U=3 with U[N]=0 → result=3.
- Sub no wrap: M=13, x=9, y=4, subtract=1 → exactly one add_start; result=5; done 1 adder latency + 3 cycles after start.
- Sub with wrap: M=13, x=4, y=9 → two add_start pulses (second with add_subtract=0, b=13); result=8.
- Width extremes: M=2^(N−1)−1, x=y=M−1, add → result=M−2. Also x=0, y=M−1, sub → result=1.
- Robustness:
  - start pulsed while busy → ignored; the first operation's result is unchanged.
  - Adder model withholding add_done → error=1 and done exactly TIMEOUT cycles after add_start.
  - resetn pulsed low during W1 → all outputs 0; no done pulse; the next start completes normally.
